// File: rtl/tpu_pkg.sv
// Shared instruction format and constants for the TPU instruction feeder.
package tpu_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  len;
    logic [15:0] operand;
  } instr_type;

  localparam instr_type  INIT_INSTR  = '{opcode: 8'h00, len: 8'h00, operand: 16'h0000};
  localparam logic [7:0] SYNC_OPCODE = 8'hFF;

  typedef enum logic {
    ISSUE     = 1'b0,
    WAIT_SYNC = 1'b1
  } feeder_state_e;

  function automatic logic is_sync(input instr_type i);
    return i.opcode == SYNC_OPCODE;
  endfunction

endpackage

// File: rtl/tpu_instr_fifo.sv
// Dual-pointer circular instruction buffer; head entry is visible combinationally on rd_data.
module tpu_instr_fifo
  import tpu_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  instr_type                wr_data,
  output instr_type                rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  instr_type     mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  // Full/empty come from registered state, so a push while full is dropped
  // even if a pop happens on the same edge.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/tpu_instr_feeder.sv
// Host-to-tpu_core instruction feeder: FIFO plus issue FSM that stalls after a SYNC.
// Optional TPU_INSTR_FEEDER_STATS_EN adds a wrapping issued_count output.
module tpu_instr_feeder
  import tpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          flush,
  input  instr_type                     wr_instr,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output instr_type                     instr_port,
  output logic                          instr_enable,
  input  logic                          busy,
  input  logic                          synchronize,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          empty,
  output logic                          sync_pending,
  output logic                          overflow
`ifdef TPU_INSTR_FEEDER_STATS_EN
  ,
  output logic [31:0]                   issued_count
`endif
);

  feeder_state_e state_q, state_d;
  instr_type     instr_port_q, instr_port_d;
  logic          instr_enable_q, instr_enable_d;
  logic          overflow_q, overflow_d;
  logic          issue;

  instr_type     head;
  logic          fifo_full, fifo_empty;

  tpu_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (wr_valid),
    .pop     (issue),
    .wr_data (wr_instr),
    .rd_data (head),
    .count   (fill_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      ISSUE: begin
        issue = enable && !busy && !fifo_empty;
        if (issue && is_sync(head)) state_d = WAIT_SYNC;
      end
      WAIT_SYNC: if (synchronize) state_d = ISSUE;
      default:   state_d = ISSUE;
    endcase
    if (flush) begin
      state_d = ISSUE;
      issue   = 1'b0;
    end
  end

  always_comb begin
    instr_port_d   = issue ? head : instr_port_q;
    instr_enable_d = issue;
    overflow_d     = flush ? 1'b0 : (overflow_q || (wr_valid && fifo_full));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ISSUE;
      instr_port_q   <= INIT_INSTR;
      instr_enable_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_port_q   <= instr_port_d;
      instr_enable_q <= instr_enable_d;
      overflow_q     <= overflow_d;
    end
  end

`ifdef TPU_INSTR_FEEDER_STATS_EN
  // Counts issues, not flushes; free-running wrap is intended.
  logic [31:0] issued_count_q, issued_count_d;

  always_comb issued_count_d = issue ? issued_count_q + 32'd1 : issued_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) issued_count_q <= '0;
    else      issued_count_q <= issued_count_d;
  end

  assign issued_count = issued_count_q;
`endif

  assign wr_ready     = !fifo_full;
  assign empty        = fifo_empty;
  assign instr_port   = instr_port_q;
  assign instr_enable = instr_enable_q;
  assign sync_pending = (state_q == WAIT_SYNC);
  assign overflow     = overflow_q;

endmodule

// File: doc/tpu_instr_feeder.md
TPU_INSTR_FEEDER -- requirements
Module: tpu_instr_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 32, meaning instruction slots (power of two, >=2).
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port enable  in  1  issue enable; push side is unaffected.
REQ-005 SHALL have port flush  in  1  synchronous FIFO clear.
REQ-006 SHALL have port wr_instr  in  instr_type  host instruction to enqueue.
REQ-007 SHALL have port wr_valid  in  1  host push request.
REQ-008 SHALL have port wr_ready  out  1  FIFO not full.
REQ-009 SHALL have port instr_port  out  instr_type  instruction to tpu_core.
REQ-010 SHALL have port instr_enable  out  1  one-cycle strobe qualifying instr_port.
REQ-011 SHALL have port busy  in  1  tpu_core cannot accept an instruction.
REQ-012 SHALL have port synchronize  in  1  tpu_core pulse: synchronize instruction completed.
REQ-013 SHALL have port fill_level  out  $clog2(FIFO_DEPTH)+1  occupied slots.
REQ-014 SHALL have port empty  out  1  fill_level == 0.
REQ-015 SHALL have port sync_pending  out  1  high while in WAIT_SYNC.
REQ-016 SHALL have port overflow  out  1  sticky: wr_valid seen while full.

Function
REQ-017 SHALL accept a push on a clock edge where wr_valid && wr_ready; wr_ready = (fill_level != FIFO_DEPTH), from registered state.
REQ-018 SHALL store instructions in a circular buffer with read/write pointers wrapping at FIFO_DEPTH-1 -> 0.
REQ-019 SHALL have states ISSUE and WAIT_SYNC.
REQ-020 SHALL, in ISSUE with enable && !busy && !empty, register the head entry into instr_port, assert instr_enable for that cycle only, and pop.
REQ-021 SHALL hold instr_port at its last value and drive instr_enable 0 when no issue occurs.
REQ-022 SHALL give latency: an instruction pushed at edge N into an empty FIFO is on instr_port with instr_enable=1 after edge N+1; no same-cycle bypass.
REQ-023 SHALL issue at most one instruction per cycle, back-to-back while conditions hold.
REQ-024 SHALL, on issuing an instruction with opcode SYNC_OPCODE, transition ISSUE -> WAIT_SYNC after that edge.
REQ-025 SHALL, in WAIT_SYNC, issue nothing and return to ISSUE on the edge where synchronize=1.
REQ-026 SHALL ignore synchronize in ISSUE.
REQ-027 SHALL allow push and pop in the same cycle with fill_level unchanged.
REQ-028 SHALL, on a push attempt while full, drop the data, leave the FIFO unchanged, and set overflow.
REQ-029 SHALL give flush priority over push, pop and synchronize: pointers and fill_level zeroed, state ISSUE, overflow cleared, instr_enable 0 next cycle.
REQ-030 SHALL keep busy sampled in the same cycle as the issue decision; busy=1 blocks the pop with no loss.

Reset
REQ-031 SHALL, while rst=0, immediately force: state ISSUE, pointers 0, fill_level 0, empty 1, wr_ready 1, instr_enable 0, instr_port INIT_INSTR, sync_pending 0, overflow 0.
REQ-032 SHALL discard all queued instructions on reset mid-operation, including a pending WAIT_SYNC.

Configuration
REQ-033 SHALL, with TPU_INSTR_FEEDER_STATS_EN defined, add output issued_count (32 bits): reset 0, +1 per instr_enable pulse, wraps, unaffected by flush; without the macro the port and counter SHALL not exist.

Structure
REQ-034 SHALL take instr_type, INIT_INSTR and SYNC_OPCODE (8'hFF) from tpu_pkg.
REQ-035 SHALL implement storage as one sub-module, tpu_instr_fifo (dual-pointer circular buffer); issue FSM and sync logic in the top.

Verification
REQ-036 SHALL cover: empty FIFO, push opcode 8'h09 len 14 at edge N, busy=0 -> instr_enable=1 with that instruction after N+1, fill_level back to 0.
REQ-037 SHALL cover: push 4 instructions (09, 21, 99, FF), busy=0 -> 4 consecutive instr_enable pulses in order; sync_pending=1 after the FF issue.
REQ-038 SHALL cover: WAIT_SYNC with 2 more queued, synchronize held 0 for 10 cycles -> no issue; synchronize pulse -> next instruction issued on the following cycle.
REQ-039 SHALL cover: FIFO_DEPTH pushes with busy=1 -> wr_ready=0, extra push sets overflow, contents intact; busy=0 -> FIFO_DEPTH issues in order across pointer wrap.
REQ-040 SHALL cover: rst=0 asserted mid-stream and flush in the same cycle as push -> all outputs at reset/flush values, no instr_enable, fill_level 0.
